sticky_flag_reader: RTL and testbench

STICKY_FLAG_READER -- requirements
Module: sticky_flag_reader

---
 rtl/sticky_flag_pkg.sv | 14 +
 rtl/sticky_flag_reader_sat_counter.sv | 41 ++++
 rtl/sticky_flag_reader.sv | 152 +++++++++++++++
 tb/tb_sticky_flag_reader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sticky_flag_pkg.sv
// sticky_flag_pkg -- shared definitions for the sticky flag reader.
// Provides the read-handshake FSM state encoding and its width.
package sticky_flag_pkg;

    localparam int unsigned STATE_W = 2;

    // Read handshake states: wait for request, capture/clear, hold response
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_SNAP = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage : sticky_flag_pkg

// File: rtl/sticky_flag_reader_sat_counter.sv
// sat_counter -- saturating up-counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one this cycle
//   clr        : restart from zero; clr wins over the held count, and an inc in
//                the same cycle is still counted on top of the cleared value
//   cnt        : registered count, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] base;

    // Next count: clear selects a zero base, inc adds one unless saturated
    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && !(&base)) begin
            cnt_d = base + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/sticky_flag_reader.sv
// sticky_flag_reader -- accumulates per-bit event pulses into sticky flags and
// lets a reader atomically snapshot-and-clear them through a req/valid/ack
// handshake. A saturating counter reports how many cycles raised at least one
// new flag since the previous snapshot.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ev_in       : per-bit event pulses, sampled every cycle
//   rd_req      : start a snapshot (ignored while busy)
//   rd_valid    : snapshot presented on rd_data / rd_cnt
//   rd_ack      : reader accepts the snapshot (only meaningful while rd_valid)
//   rd_data     : captured sticky flags
//   rd_cnt      : new-flag cycle count at capture time
//   busy        : handshake FSM not idle
//   irq_mask    : (STICKY_FLAG_IRQ_EN only) per-bit interrupt enable
//   irq         : (STICKY_FLAG_IRQ_EN only) registered |(sticky & irq_mask)
// Optional feature: define STICKY_FLAG_IRQ_EN to add the interrupt output.
module sticky_flag_reader
    import sticky_flag_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ev_in,
    input  logic             rd_req,
    output logic             rd_valid,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] rd_cnt,
`ifdef STICKY_FLAG_IRQ_EN
    input  logic [WIDTH-1:0] irq_mask,
    output logic             irq,
`endif
    output logic             busy
);

    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   sticky_q;
    logic [WIDTH-1:0]   sticky_d;
    logic [WIDTH-1:0]   rd_data_q;
    logic [WIDTH-1:0]   rd_data_d;
    logic [CNT_W-1:0]   rd_cnt_q;
    logic [CNT_W-1:0]   rd_cnt_d;
    logic               rd_valid_q;
    logic               rd_valid_d;
    logic               busy_q;
    logic               busy_d;
    logic [WIDTH-1:0]   clr_mask;
    logic [WIDTH-1:0]   kept;
    logic               new_flag;
    logic               snap;
    logic [CNT_W-1:0]   evt_cnt;

    // Handshake FSM, snapshot capture and flag update
    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        rd_cnt_d  = rd_cnt_q;
        clr_mask  = '0;
        snap      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                // Capture and clear exactly the flags that were captured
                snap      = 1'b1;
                clr_mask  = sticky_q;
                rd_data_d = sticky_q;
                rd_cnt_d  = evt_cnt;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (rd_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // New events OR in after the clear so a same-cycle event is never lost
        kept     = sticky_q & ~clr_mask;
        sticky_d = kept | ev_in;
        // A flag is new if it was clear after this cycle's clear mask applies
        new_flag = |(ev_in & ~kept);

        rd_valid_d = (state_d == ST_RESP);
        busy_d     = (state_d != ST_IDLE);
    end

    // New-flag cycle counter, restarted by each snapshot
    sat_counter #(
        .W (CNT_W)
    ) u_evt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (new_flag),
        .clr   (snap),
        .cnt   (evt_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sticky_q   <= '0;
            rd_data_q  <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sticky_q   <= sticky_d;
            rd_data_q  <= rd_data_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign rd_cnt   = rd_cnt_q;
    assign busy     = busy_q;

`ifdef STICKY_FLAG_IRQ_EN
    logic irq_q;
    logic irq_d;

    // Interrupt follows the masked flags one cycle late
    always_comb begin
        irq_d = |(sticky_q & irq_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

endmodule : sticky_flag_reader

// File: tb/tb_sticky_flag_reader.sv
// tb_sticky_flag_reader -- self-checking bench for sticky_flag_reader.
// Define STICKY_FLAG_IRQ_EN to also exercise the interrupt output.
module tb_sticky_flag_reader;

    localparam int unsigned W       = 8;
    localparam int unsigned C       = 4;
    localparam int          CNT_MAX = 15;
    localparam int unsigned SW      = 20;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] ev_in;
    logic         rd_req;
    logic         rd_ack;
    logic         rd_valid;
    logic [W-1:0] rd_data;
    logic [C-1:0] rd_cnt;
    logic         busy;
    logic [W-1:0] irq_mask;
`ifdef STICKY_FLAG_IRQ_EN
    logic         irq;
    logic         irq2;
`endif

    logic [SW-1:0] ev2;
    logic          rd_req2;
    logic          rd_ack2;
    logic          rd_valid2;
    logic [SW-1:0] rd_data2;
    logic [C-1:0]  rd_cnt2;
    logic          busy2;

    sticky_flag_reader #(.WIDTH(W), .CNT_W(C)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_in    (ev_in),
        .rd_req   (rd_req),
        .rd_valid (rd_valid),
        .rd_ack   (rd_ack),
        .rd_data  (rd_data),
        .rd_cnt   (rd_cnt),
`ifdef STICKY_FLAG_IRQ_EN
        .irq_mask (irq_mask),
        .irq      (irq),
`endif
        .busy     (busy)
    );

    // Wide instance so more than 2^CNT_W-1 distinct new flags fit between reads
    sticky_flag_reader #(.WIDTH(SW), .CNT_W(C)) u_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_in    (ev2),
        .rd_req   (rd_req2),
        .rd_valid (rd_valid2),
        .rd_ack   (rd_ack2),
        .rd_data  (rd_data2),
        .rd_cnt   (rd_cnt2),
`ifdef STICKY_FLAG_IRQ_EN
        .irq_mask ({SW{1'b0}}),
        .irq      (irq2),
`endif
        .busy     (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: flags as a set, count, phase 0=idle 1=capture 2=respond
    logic [W-1:0] m_sticky;
    int           m_cnt;
    int           m_phase;
    logic [W-1:0] m_data;
    int           m_cnt_out;
    logic         m_irq;

    typedef struct {
        logic [W-1:0] ev;
        logic         req;
        logic         ack;
        logic         valid;
        logic         bsy;
        logic [W-1:0] data;
        logic [C-1:0] cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sticky  = '0;
        m_cnt     = 0;
        m_phase   = 0;
        m_data    = '0;
        m_cnt_out = 0;
        m_irq     = 1'b0;
    endtask

    task automatic model_step(input logic [W-1:0] ev, input logic req, input logic ack);
        logic [W-1:0] prev;
        prev  = m_sticky;
        m_irq = |(prev & irq_mask);
        if (m_phase == 1) begin
            // Reader takes the flags; whatever arrives now is the next epoch
            m_data    = prev;
            m_cnt_out = m_cnt;
            m_cnt     = (ev != '0) ? 1 : 0;
            m_sticky  = ev;
            m_phase   = 2;
        end else begin
            if ((ev & ~prev) != '0) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_sticky = prev | ev;
            if (m_phase == 0 && req) m_phase = 1;
            else if (m_phase == 2 && ack) m_phase = 0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 32'(rd_valid), 32'(m_phase == 2));
        check({tag, "_busy"},  32'(busy),     32'(m_phase != 0));
        check({tag, "_data"},  32'(rd_data),  32'(m_data));
        check({tag, "_cnt"},   32'(rd_cnt),   32'(m_cnt_out));
`ifdef STICKY_FLAG_IRQ_EN
        check({tag, "_irq"},   32'(irq),      32'(m_irq));
`endif
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cyc(input logic [W-1:0] ev, input logic req, input logic ack, input string tag);
        ev_in  = ev;
        rd_req = req;
        rd_ack = ack;
        @(posedge clk);
        model_step(ev, req, ack);
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        logic [W-1:0] ev_r;
        logic         req_r;
        logic         ack_r;

        rst_n    = 1'b0;
        ev_in    = '0;
        rd_req   = 1'b0;
        rd_ack   = 1'b0;
        irq_mask = '0;
        ev2      = '0;
        rd_req2  = 1'b0;
        rd_ack2  = 1'b0;
        model_reset();

        tbl[0]  = '{8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[1]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[2]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0};
        tbl[3]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 4'd1};
        tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 4'd1};
        tbl[5]  = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h05, 4'd1};
        tbl[6]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'd0};
        tbl[7]  = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[8]  = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0};
        tbl[9]  = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0};
        tbl[10] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd1};
        tbl[11] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 4'd1};
        tbl[12] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 4'd1};
        tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 4'd1};
        tbl[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 4'd1};
        tbl[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 4'd1};

        // Reset values while held in reset
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_data",  32'(rd_data),  32'd0);
        check("rst_cnt",   32'(rd_cnt),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table: basic read, clear on read, event held across capture
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].ev, tbl[i].req, tbl[i].ack, "tbl");
            check($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(tbl[i].valid));
            check($sformatf("vec%0d_busy", i),  32'(busy),     32'(tbl[i].bsy));
            check($sformatf("vec%0d_data", i),  32'(rd_data),  32'(tbl[i].data));
            check($sformatf("vec%0d_cnt", i),   32'(rd_cnt),   32'(tbl[i].cnt));
        end

        // Response held with ack withheld; a request in RESP must be ignored
        cyc(8'h30, 1'b0, 1'b0, "hold");
        cyc(8'h00, 1'b1, 1'b0, "hold");
        cyc(8'h00, 1'b0, 1'b0, "hold");
        for (int i = 0; i < 5; i++) begin
            cyc((i == 2) ? 8'h40 : 8'h00, (i == 1) ? 1'b1 : 1'b0, 1'b0, "hold");
            check("hold_data",  32'(rd_data),  32'h30);
            check("hold_busy",  32'(busy),     32'd1);
            check("hold_valid", 32'(rd_valid), 32'd1);
        end
        cyc(8'h00, 1'b0, 1'b1, "hold");
        cyc(8'h00, 1'b0, 1'b0, "hold");
        check("hold_no_second", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a response, with X on the events
        cyc(8'h00, 1'b1, 1'b0, "mrst");
        cyc(8'h00, 1'b0, 1'b0, "mrst");
        check("mrst_pre_valid", 32'(rd_valid), 32'd1);
        ev_in = 'x;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_valid", 32'(rd_valid), 32'd0);
        check("mrst_data",  32'(rd_data),  32'd0);
        check("mrst_busy",  32'(busy),     32'd0);
        @(negedge clk);
        ev_in = 8'hFF;
        @(negedge clk);
        rst_n = 1'b1;
        ev_in = '0;
        model_reset();
        cyc(8'h00, 1'b1, 1'b0, "mrst");
        cyc(8'h00, 1'b0, 1'b0, "mrst");
        check("mrst_flags_clear", 32'(rd_data), 32'd0);
        check("mrst_cnt_clear",   32'(rd_cnt),  32'd0);
        cyc(8'h00, 1'b0, 1'b1, "mrst");

`ifdef STICKY_FLAG_IRQ_EN
        // Interrupt masking and one-cycle lag, cleared by a completed read
        irq_mask = 8'h02;
        cyc(8'h01, 1'b0, 1'b0, "irq");
        cyc(8'h00, 1'b0, 1'b0, "irq");
        check("irq_masked", 32'(irq), 32'd0);
        cyc(8'h02, 1'b0, 1'b0, "irq");
        check("irq_lag", 32'(irq), 32'd0);
        cyc(8'h00, 1'b0, 1'b0, "irq");
        check("irq_set", 32'(irq), 32'd1);
        cyc(8'h00, 1'b1, 1'b0, "irq");
        cyc(8'h00, 1'b0, 1'b0, "irq");
        cyc(8'h00, 1'b0, 1'b1, "irq");
        check("irq_clr", 32'(irq), 32'd0);
`endif

        // Saturation: 20 distinct new flags on the wide instance
        for (int i = 0; i < 20; i++) begin
            ev2 = SW'(1) << i;
            cyc(8'h00, 1'b0, 1'b0, "sat_bg");
        end
        ev2     = '0;
        rd_req2 = 1'b1;
        cyc(8'h00, 1'b0, 1'b0, "sat_bg");
        rd_req2 = 1'b0;
        cyc(8'h00, 1'b0, 1'b0, "sat_bg");
        check("sat_valid", 32'(rd_valid2), 32'd1);
        check("sat_cnt",   32'(rd_cnt2),   32'd15);
        check("sat_data",  32'(rd_data2),  32'h000F_FFFF);
        rd_ack2 = 1'b1;
        cyc(8'h00, 1'b0, 1'b0, "sat_bg");
        rd_ack2 = 1'b0;
        check("sat_idle", 32'(busy2), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) irq_mask = W'($urandom);
            ev_r  = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            req_r = ($urandom_range(0, 5) == 0);
            ack_r = ($urandom_range(0, 2) == 0);
            cyc(ev_r, req_r, ack_r, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sticky_flag_reader
